// File: rtl/la_fork3.sv
// la_fork3: one-word buffered 1-to-3 stream fork.
// Each accepted word is held once and handed to all three branches.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_data [DW]        upstream payload
//   out_valid [3]       per-branch valid (bit i = branch i)
//   out_ready [3]       per-branch ready
//   out_data [DW]       payload shared by all branches
module la_fork3 #(
  parameter string PROP = "DEFAULT",
  parameter int    DW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [2:0]    out_valid,
  input  logic [2:0]    out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] r_data;
  logic [2:0]    r_pend;
  logic          w_in_hs;
  logic          w_unused_prop;

  // PROP only tags the implementation; it has no functional effect.
  assign w_unused_prop = (PROP == "");

  // Free when every branch either owes nothing or finishes now.
  // Deliberately independent of in_valid.
  assign in_ready = &(~r_pend | out_ready);
  assign w_in_hs  = in_valid & in_ready;

  assign out_valid = r_pend;
  assign out_data  = r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= 3'b000;
      r_data <= '0;
    end else if (w_in_hs) begin
      r_pend <= 3'b111;
      r_data <= in_data;
    end else begin
      // ready on an idle branch clears a bit already clear
      r_pend <= r_pend & ~out_ready;
    end
  end

endmodule

// File: tb/tb_la_fork3.sv
// tb_la_fork3: directed and scoreboarded checks of la_fork3.
// Inputs change 1 ns after each rising edge; outputs sampled there.
module tb_la_fork3;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] out_valid;
  logic [2:0] out_ready;
  logic [7:0] out_data;

  int n_tests;
  int n_fail;

  la_fork3 #(.PROP("DEFAULT"), .DW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_q [$];
  int         rd [3];
  logic       acc;
  logic       any_v;
  logic [7:0] prev_d;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 3'b000;
    step();
    step();

    // reset state
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);

    // single word, all ready
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    out_ready = 3'b111;
    #1;
    chk("a5_rdy_pre", 32'(in_ready), 32'h1);
    step();
    chk("a5_valid", 32'(out_valid), 32'h7);
    chk("a5_data", 32'(out_data), 32'hA5);
    chk("a5_rdy", 32'(in_ready), 32'h1);
    in_valid = 1'b0;
    step();
    chk("a5_drain", 32'(out_valid), 32'h0);

    // ready on idle branches is ignored
    step();
    chk("idle_ign", 32'(out_valid), 32'h0);

    // staggered branch completion; stalled offer must not load
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    out_ready = 3'b000;
    step();
    chk("3c_load", 32'(out_valid), 32'h7);
    in_data   = 8'h99;
    out_ready = 3'b001;
    #1;
    chk("3c_rdy0", 32'(in_ready), 32'h0);
    step();
    chk("3c_v110", 32'(out_valid), 32'h6);
    chk("3c_d1", 32'(out_data), 32'h3C);
    out_ready = 3'b010;
    #1;
    chk("3c_rdy1", 32'(in_ready), 32'h0);
    step();
    chk("3c_v100", 32'(out_valid), 32'h4);
    chk("3c_d2", 32'(out_data), 32'h3C);
    in_valid  = 1'b0;
    out_ready = 3'b100;
    #1;
    chk("3c_rdy2", 32'(in_ready), 32'h1);
    step();
    chk("3c_v000", 32'(out_valid), 32'h0);
    chk("3c_d3", 32'(out_data), 32'h3C);

    // streaming 01..10 at full rate
    out_ready = 3'b111;
    in_valid  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = 8'(i);
      #1;
      chk("strm_rdy", 32'(in_ready), 32'h1);
      step();
      chk("strm_valid", 32'(out_valid), 32'h7);
      chk("strm_data", 32'(out_data), 32'(i));
    end
    in_valid = 1'b0;
    step();
    chk("strm_end", 32'(out_valid), 32'h0);

    // final completion plus new word, no bubble
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 3'b000;
    step();
    in_valid  = 1'b0;
    out_ready = 3'b011;
    step();
    chk("55_v100", 32'(out_valid), 32'h4);
    chk("55_data", 32'(out_data), 32'h55);
    in_valid  = 1'b1;
    in_data   = 8'h66;
    out_ready = 3'b100;
    #1;
    chk("66_rdy", 32'(in_ready), 32'h1);
    step();
    chk("66_valid", 32'(out_valid), 32'h7);
    chk("66_data", 32'(out_data), 32'h66);

    // reset mid-transfer beats a concurrent handshake
    in_valid  = 1'b0;
    out_ready = 3'b100;
    step();
    chk("66_v011", 32'(out_valid), 32'h3);
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 3'b011;
    step();
    chk("mrst_valid", 32'(out_valid), 32'h0);
    chk("mrst_data", 32'(out_data), 32'h0);
    chk("mrst_rdy", 32'(in_ready), 32'h1);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 3'b111;
    step();
    chk("mrst_gone", 32'(out_valid), 32'h0);

    // random traffic against a per-branch scoreboard
    exp_q.delete();
    for (int b = 0; b < 3; b++) rd[b] = 0;
    acc      = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
      end
      out_ready = 3'($urandom);
      #1;
      for (int b = 0; b < 3; b++) begin
        if (out_valid[b] && out_ready[b]) begin
          if (rd[b] < exp_q.size()) begin
            chk("sb_data", 32'(out_data), 32'(exp_q[rd[b]]));
          end else begin
            chk("sb_extra", 32'(rd[b]), 32'(exp_q.size()));
          end
          rd[b]++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(in_data);
      any_v  = |out_valid;
      prev_d = out_data;
      step();
      if (any_v && !acc) chk("sb_stable", 32'(out_data), 32'(prev_d));
    end
    in_valid  = 1'b0;
    out_ready = 3'b111;
    #1;
    for (int b = 0; b < 3; b++) begin
      if (out_valid[b]) begin
        if (rd[b] < exp_q.size())
          chk("sb_tail", 32'(out_data), 32'(exp_q[rd[b]]));
        rd[b]++;
      end
    end
    step();
    chk("sb_empty", 32'(out_valid), 32'h0);
    for (int b = 0; b < 3; b++)
      chk("sb_count", 32'(rd[b]), 32'(exp_q.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
